cv32e40p_div_operand_issue: RTL and testbench
=============================================

// Module: cv32e40p_div_operand_issue
// PURPOSE
//  Front-end stage for the serial divider (cv32e40p_alu_div).
//  - Accepts one div/rem request over a valid/ready handshake and registers the operands.
//  - Derives the divider's side-band inputs: OpBShift, OpBIsZero and OpBSign.
//  - Issues a single InVld pulse and waits for the divider result.
//  - Returns the result on a valid/ready response port. Supports flush of an in-flight op.
//  - Only one operation is outstanding at a time.
// PARAMETERS
//  C_WIDTH      32  operand/result width
//  C_LOG_WIDTH  6   width of the shift field; must hold values 0..C_WIDTH
// PORTS
//  Clk_CI           in   1            clock
//  Rst_RI           in   1            asynchronous reset, active-high
//  ReqVld_SI        in   1            request valid
//  ReqRdy_SO        out  1            request ready
//  ReqOpA_DI        in   C_WIDTH      dividend
//  ReqOpB_DI        in   C_WIDTH      divisor
//  ReqOpCode_SI     in   2            0 udiv, 1 div, 2 urem, 3 rem
//  Flush_SI         in   1            discard in-flight op/response
//  DivOpA_DO        out  C_WIDTH      registered OpA to divider
//  DivOpB_DO        out  C_WIDTH      registered OpB to divider
//  DivOpBShift_DO   out  C_LOG_WIDTH  divisor normalisation shift
//  DivOpBIsZero_SO  out  1            registered OpB == 0
//  DivOpBSign_SO    out  1            OpCode[0] & OpB[C_WIDTH-1]
//  DivOpCode_SO     out  2            registered opcode
//  DivInVld_SO      out  1            one-cycle start pulse
//  DivOutRdy_SO     out  1            ready for divider result
//  DivOutVld_SI     in   1            divider result valid
//  DivRes_DI        in   C_WIDTH      divider result
//  RspVld_SO        out  1            response valid
//  RspRdy_SI        in   1            response ready
//  RspRes_DO        out  C_WIDTH      response data
//  Busy_SO          out  1            state != IDLE
// BEHAVIOUR
//  Reset
//  - State IDLE; all registers and outputs 0; drop flag 0.
//  FSM
//  - IDLE: ReqRdy_SO = !Flush_SI. On ReqVld&ReqRdy, latch A, B and opcode, then go to ISSUE.
//  - ISSUE (exactly 1 cycle): DivInVld_SO = !Flush_SI.
//    - Go to WAIT, or to IDLE if Flush_SI is high.
//  - WAIT: DivOutRdy_SO = 1.
//    - Flush_SI sets the drop flag.
//    - On DivOutVld_SI: if drop or Flush_SI, go to IDLE and clear drop.
//      Otherwise latch DivRes_DI into RspRes and go to RESP.
//  - RESP: RspVld_SO = 1; RspRes_DO is stable until accepted.
//    - On RspRdy_SI go to IDLE. Flush_SI forces IDLE with no handshake.
//  Latency
//  - Request accepted in cycle N: DivInVld_SO high in N+1.
//  - DivOutVld_SI in cycle M: RspVld_SO high from M+1.
//  - No back-to-back accept: the next request can be accepted in the cycle after the response handshake.
//  Divider outputs
//  - Div* data outputs are combinational from the held registers.
//  - They are stable from ISSUE until the state leaves WAIT.
//  Shift derivation
//  - s = OpCode[0] & B[C_WIDTH-1]; v = s ? ~B : B.
//  - c = (v == 0) ? C_WIDTH-1 : clz(v).
//  - DivOpBShift_DO = c + (OpCode[0] ? 0 : 1). Range 0..C_WIDTH; the add does not wrap.
//  Other rules
//  - Response content is whatever the divider returns. This block applies no div-by-zero
//    or overflow correction.
//  - Rst_RI asserted mid-operation returns to IDLE at once; no response is produced.
//    The divider must be reset by the same Rst_RI.
// TESTING
//  1. udiv 100/7 with RspRdy held high -> DivInVld 1 cycle after accept; RspRes = 14;
//     shift = 30 (clz(7)=29, +1).
//  2. rem 0xFFFFFFF9 (-7) by 2 -> RspRes = 0xFFFFFFFF; DivOpBSign = 0.
//     div 0x80000000 by 0xFFFFFFFF -> 0x80000000; shift = 31.
//  3. udiv by 0 -> DivOpBIsZero = 1, RspRes = 0xFFFFFFFF.
//     urem 5 by 0 -> 5. udiv by 0x80000000 -> shift = 1.
//  4. Hold RspRdy low for 10 cycles after RspVld -> RspVld and RspRes stable;
//     ReqRdy stays 0; accept only after the handshake.
//  5. Flush_SI in ISSUE -> no DivInVld. Flush in WAIT -> divider result consumed,
//     no RspVld, IDLE next cycle. Flush in RESP -> RspVld drops.
//  6. Assert Rst_RI in WAIT -> all outputs 0 the same cycle; a new request after
//     reset completes with the correct result.

Source files
------------

// File: rtl/cv32e40p_div_operand_issue.sv
// ============================================================================
// Module      : cv32e40p_div_operand_issue
// Description : Operand capture and issue front-end for the serial divider.
//               Handles one div/rem request at a time and returns its result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_div_operand_issue #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    input  logic                   ReqVld_SI,
    output logic                   ReqRdy_SO,
    input  logic [C_WIDTH-1:0]     ReqOpA_DI,
    input  logic [C_WIDTH-1:0]     ReqOpB_DI,
    input  logic [1:0]             ReqOpCode_SI,
    input  logic                   Flush_SI,
    output logic [C_WIDTH-1:0]     DivOpA_DO,
    output logic [C_WIDTH-1:0]     DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
    output logic                   DivOpBIsZero_SO,
    output logic                   DivOpBSign_SO,
    output logic [1:0]             DivOpCode_SO,
    output logic                   DivInVld_SO,
    output logic                   DivOutRdy_SO,
    input  logic                   DivOutVld_SI,
    input  logic [C_WIDTH-1:0]     DivRes_DI,
    output logic                   RspVld_SO,
    input  logic                   RspRdy_SI,
    output logic [C_WIDTH-1:0]     RspRes_DO,
    output logic                   Busy_SO
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [C_WIDTH-1:0]     r_op_a;
    logic [C_WIDTH-1:0]     r_op_b;
    logic [1:0]             r_op_code;
    logic [C_LOG_WIDTH-1:0] r_shift;
    logic                   r_is_zero;
    logic                   r_drop;
    logic [C_WIDTH-1:0]     r_rsp_res;

    logic [C_LOG_WIDTH-1:0] w_shift;
    logic                   w_accept;

    // Normalisation shift: leading zeros of the magnitude-like divisor; signed
    // ops keep one bit of headroom for the sign, unsigned ops shift one further.
    function automatic logic [C_LOG_WIDTH-1:0] f_shift(input logic [C_WIDTH-1:0] b,
                                                       input logic               sgn_op);
        logic                   s;
        logic [C_WIDTH-1:0]     v;
        logic [C_LOG_WIDTH-1:0] c;
        logic                   found;
        s     = sgn_op & b[C_WIDTH-1];
        v     = s ? ~b : b;
        c     = C_LOG_WIDTH'(C_WIDTH - 1);
        found = 1'b0;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                c     = C_LOG_WIDTH'(C_WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return c + (sgn_op ? C_LOG_WIDTH'(0) : C_LOG_WIDTH'(1));
    endfunction

    always_comb begin
        w_shift = f_shift(ReqOpB_DI, ReqOpCode_SI[0]);
    end

    assign ReqRdy_SO    = (r_state == S_IDLE) && !Flush_SI && !Rst_RI;
    assign w_accept     = ReqVld_SI && ReqRdy_SO;
    assign DivInVld_SO  = (r_state == S_ISSUE) && !Flush_SI;
    assign DivOutRdy_SO = (r_state == S_WAIT);
    assign RspVld_SO    = (r_state == S_RESP);
    assign Busy_SO      = (r_state != S_IDLE);

    assign DivOpA_DO       = r_op_a;
    assign DivOpB_DO       = r_op_b;
    assign DivOpCode_SO    = r_op_code;
    assign DivOpBShift_DO  = r_shift;
    assign DivOpBIsZero_SO = r_is_zero;
    assign DivOpBSign_SO   = r_op_code[0] & r_op_b[C_WIDTH-1];
    assign RspRes_DO       = r_rsp_res;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_shift   <= '0;
            r_is_zero <= 1'b0;
            r_drop    <= 1'b0;
            r_rsp_res <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a    <= ReqOpA_DI;
                        r_op_b    <= ReqOpB_DI;
                        r_op_code <= ReqOpCode_SI;
                        r_shift   <= w_shift;
                        r_is_zero <= (ReqOpB_DI == '0);
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= Flush_SI ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // The divider cannot be aborted, so a flushed op still waits
                    // for its result and then discards it.
                    if (DivOutVld_SI) begin
                        if (r_drop || Flush_SI) begin
                            r_drop  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_rsp_res <= DivRes_DI;
                            r_state   <= S_RESP;
                        end
                    end else if (Flush_SI) begin
                        r_drop <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (RspRdy_SI || Flush_SI) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_div_operand_issue.sv
// ============================================================================
// Module      : tb_cv32e40p_div_operand_issue
// Description : Directed bench for the divider issue stage; the bench plays
//               the divider and checks against a RISC-V division model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_div_operand_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_op = '0;
    logic        flush = 1'b0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [5:0]  div_shift;
    logic        div_zero;
    logic        div_sign;
    logic [1:0]  div_code;
    logic        div_in_vld;
    logic        div_out_rdy;
    logic        div_out_vld = 1'b0;
    logic [31:0] div_res = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_res;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [1:0]  m_op = '0;
    logic [31:0] m_res = '0;

    cv32e40p_div_operand_issue #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
        .Clk_CI          (clk),
        .Rst_RI          (rst),
        .ReqVld_SI       (req_vld),
        .ReqRdy_SO       (req_rdy),
        .ReqOpA_DI       (req_a),
        .ReqOpB_DI       (req_b),
        .ReqOpCode_SI    (req_op),
        .Flush_SI        (flush),
        .DivOpA_DO       (div_a),
        .DivOpB_DO       (div_b),
        .DivOpBShift_DO  (div_shift),
        .DivOpBIsZero_SO (div_zero),
        .DivOpBSign_SO   (div_sign),
        .DivOpCode_SO    (div_code),
        .DivInVld_SO     (div_in_vld),
        .DivOutRdy_SO    (div_out_rdy),
        .DivOutVld_SI    (div_out_vld),
        .DivRes_DI       (div_res),
        .RspVld_SO       (rsp_vld),
        .RspRdy_SI       (rsp_rdy),
        .RspRes_DO       (rsp_res),
        .Busy_SO         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension division results, including the div-by-zero and
    // signed-overflow cases that the divider itself produces.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            2'd0: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: return (b == 0) ? a : a % b;
            2'd1: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    // Shift = (index distance from the MSB to the highest set bit of the
    // sign-folded divisor), plus one for unsigned ops.
    function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [1:0] op);
        logic [31:0] v;
        int          lead;
        v    = (op[0] && b[31]) ? ~b : b;
        lead = 31;
        if (v != 0) begin
            lead = 0;
            while (v[31 - lead] == 1'b0) lead++;
        end
        return 32'(lead + (op[0] ? 0 : 1));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (div_in_vld || div_out_rdy) begin
                chk("div_op_a", div_a, m_a);
                chk("div_op_b", div_b, m_b);
                chk("div_op_code", 32'(div_code), 32'(m_op));
                chk("div_shift_model", 32'(div_shift), ref_shift(m_b, m_op));
                chk("div_is_zero", 32'(div_zero), 32'(m_b == 0));
                chk("div_sign", 32'(div_sign), 32'(m_op[0] & m_b[31]));
            end
            if (rsp_vld) chk("rsp_res_model", rsp_res, m_res);
        end
    end

    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        m_a    = a;
        m_b    = b;
        m_op   = op;
        m_res  = ref_res(a, b, op);
        req_vld = 1'b1;
        req_a   = a;
        req_b   = b;
        req_op  = op;
        @(negedge clk);
        chk("req_rdy_idle", 32'(req_rdy), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input int lat, input int hold,
                         input logic [31:0] lit_res, input logic [31:0] lit_shift);
        send_req(a, b, op);
        @(negedge clk);
        chk("in_vld_issue", 32'(div_in_vld), 32'd1);
        chk("req_rdy_issue", 32'(req_rdy), 32'd0);
        chk("shift_literal", 32'(div_shift), lit_shift);
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("in_vld_wait", 32'(div_in_vld), 32'd0);
            chk("out_rdy_wait", 32'(div_out_rdy), 32'd1);
            chk("rsp_vld_wait", 32'(rsp_vld), 32'd0);
            @(posedge clk); #1;
        end
        div_out_vld = 1'b1;
        div_res     = m_res;
        @(negedge clk);
        chk("out_rdy_done", 32'(div_out_rdy), 32'd1);
        chk("rsp_vld_early", 32'(rsp_vld), 32'd0);
        @(posedge clk); #1;
        div_out_vld = 1'b0;
        div_res     = 32'hDEAD_BEEF;
        rsp_rdy     = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            req_vld = 1'b1;
            @(negedge clk);
            chk("rsp_vld_hold", 32'(rsp_vld), 32'd1);
            chk("rsp_res_hold", rsp_res, lit_res);
            chk("req_rdy_hold", 32'(req_rdy), 32'd0);
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("rsp_vld", 32'(rsp_vld), 32'd1);
        chk("rsp_res_literal", rsp_res, lit_res);
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        @(negedge clk);
        chk("rsp_vld_after", 32'(rsp_vld), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("req_rdy_after", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift", 32'(div_shift), 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(32'd100, 32'd7, 2'd0, 3, 0, 32'd14, 32'd30);
        do_op(32'hFFFF_FFF9, 32'd2, 2'd3, 2, 0, 32'hFFFF_FFFF, 32'd30);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 1, 0, 32'h8000_0000, 32'd31);
        do_op(32'd1234, 32'd0, 2'd0, 0, 0, 32'hFFFF_FFFF, 32'd32);
        do_op(32'd5, 32'd0, 2'd2, 2, 0, 32'd5, 32'd32);
        do_op(32'hC000_0000, 32'h8000_0000, 2'd0, 1, 0, 32'd1, 32'd1);
        do_op(32'hFFFF_FF9C, 32'd7, 2'd1, 4, 0, 32'hFFFF_FFF2, 32'd29);
        do_op(32'hFFFF_FF9C, 32'd7, 2'd3, 2, 1, 32'hFFFF_FFFE, 32'd29);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 1, 0, 32'd0, 32'd31);
        do_op(32'd1000, 32'd10, 2'd0, 2, 10, 32'd100, 32'd29);

        // Flush while idle blocks acceptance
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;

        // Flush in ISSUE: no start pulse, back to idle
        send_req(32'd50, 32'd5, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_issue_in_vld", 32'(div_in_vld), 32'd0);
        chk("flush_issue_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_issue_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Flush in WAIT: result consumed later, no response
        send_req(32'd81, 32'd9, 2'd2);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_out_rdy", 32'(div_out_rdy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_wait_still_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        div_out_vld = 1'b1;
        div_res     = m_res;
        @(negedge clk);
        chk("flush_wait_rsp_vld", 32'(rsp_vld), 32'd0);
        @(posedge clk); #1;
        div_out_vld = 1'b0;
        @(negedge clk);
        chk("flush_wait_idle", 32'(busy), 32'd0);
        chk("flush_wait_no_rsp", 32'(rsp_vld), 32'd0);
        @(posedge clk); #1;

        // Flush in RESP: response withdrawn without handshake
        send_req(32'd9, 32'd3, 2'd0);
        @(posedge clk); #1;
        div_out_vld = 1'b1;
        div_res     = m_res;
        @(posedge clk); #1;
        div_out_vld = 1'b0;
        @(negedge clk);
        chk("flush_resp_vld", 32'(rsp_vld), 32'd1);
        chk("flush_resp_res", rsp_res, 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_dropped", 32'(rsp_vld), 32'd0);
        chk("flush_resp_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in WAIT
        send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_rdy", 32'(div_out_rdy), 32'd0);
        chk("arst_req_rdy", 32'(req_rdy), 32'd0);
        chk("arst_div_a", div_a, 32'd0);
        chk("arst_div_b", div_b, 32'd0);
        chk("arst_shift", 32'(div_shift), 32'd0);
        chk("arst_sign_zero", {30'd0, div_sign, div_zero}, 32'd0);
        chk("arst_rsp", {31'd0, rsp_vld}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd77, 32'd11, 2'd0, 2, 0, 32'd7, 32'd29);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
